// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/write-back bus of the register file with load-use scoreboard
// master drives read addresses, write-back, producer issue and trigger;
// slave (the register file) returns read data, stall, pending count and debug taps.
interface regfile_sb_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_PORTS    = 2
);
  logic [READ_PORTS*ADDRESS_WIDTH-1:0] rd_addr;
  logic [READ_PORTS-1:0]               rd_used;
  logic [READ_PORTS*DATA_WIDTH-1:0]    rd_data;
  logic                                we;
  logic [ADDRESS_WIDTH-1:0]            wa;
  logic [DATA_WIDTH-1:0]               wd;
  logic                                wb_pend_clr;
  logic                                iss_valid;
  logic [ADDRESS_WIDTH-1:0]            iss_rd;
  logic                                trigger;
  logic                                stall;
  logic [ADDRESS_WIDTH:0]              pend_cnt;
  logic [DATA_WIDTH-1:0]               ra;
  logic [DATA_WIDTH-1:0]               a0;
  modport master (
    output rd_addr, rd_used, we, wa, wd, wb_pend_clr, iss_valid, iss_rd, trigger,
    input  rd_data, stall, pend_cnt, ra, a0
  );
  modport slave (
    input  rd_addr, rd_used, we, wa, wd, wb_pend_clr, iss_valid, iss_rd, trigger,
    output rd_data, stall, pend_cnt, ra, a0
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: RV32I register file with combinational reads, load-use scoreboard and debug taps
// Ports: clk, rst_n (async active-low), bus (regfile_sb_if.slave: reads, write-back,
// producer issue, trigger, stall, pend_cnt, ra, a0).
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read and trigger forwarding.
module regfile_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_PORTS    = 2,
  parameter int TRIGGER_REG   = 5,
  parameter int RA_REG        = 1,
  parameter int A0_REG        = 10
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDRESS_WIDTH;
  localparam int CW = ADDRESS_WIDTH + 1;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend, pend_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [READ_PORTS-1:0] stall_v;
  logic [READ_PORTS*DATA_WIDTH-1:0] rd_data_v;
  // x0 is only ever written by reset, so it reads 0 without a special case
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else
      for (int i = 1; i < DEPTH; i++)
        if (bus.trigger && i == TRIGGER_REG) regs[i] <= DATA_WIDTH'(1);
        else if (bus.we && bus.wa == ADDRESS_WIDTH'(i)) regs[i] <= bus.wd;
  // set is applied after clear so a newer producer supersedes the retiring one
  always_comb begin
    pend_nxt = pend;
    if (bus.we && bus.wb_pend_clr) pend_nxt[bus.wa] = 1'b0;
    if (bus.iss_valid) pend_nxt[bus.iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] a;
    assign a = bus.rd_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = bus.we && bus.wa == a && a != '0;
    assign rd_data_v[g*DATA_WIDTH +: DATA_WIDTH] =
      (bus.trigger && a == ADDRESS_WIDTH'(TRIGGER_REG)) ? DATA_WIDTH'(1) : hit ? bus.wd : regs[a];
    assign stall_v[g] = bus.rd_used[g] && pend[a] && !(hit && bus.wb_pend_clr);
`else
    assign rd_data_v[g*DATA_WIDTH +: DATA_WIDTH] = regs[a];
    assign stall_v[g] = bus.rd_used[g] && pend[a];
`endif
  end
  assign bus.rd_data  = rd_data_v;
  assign bus.stall    = |stall_v;
  assign bus.pend_cnt = cnt;
  assign bus.ra       = regs[RA_REG];
  assign bus.a0       = regs[A0_REG];
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench for regfile_sb
module tb_regfile_sb;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RP = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  regfile_sb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(RP)) bus ();
  regfile_sb #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_PORTS(RP),
    .TRIGGER_REG(5), .RA_REG(1), .A0_REG(10)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {int kind; logic [31:0] exp; string name;} exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  event check_now;
  function automatic logic [31:0] actual(int kind);
    case (kind)
      0: return bus.rd_data[31:0];
      1: return bus.rd_data[63:32];
      2: return 32'(bus.stall);
      3: return 32'(bus.pend_cnt);
      4: return bus.ra;
      default: return bus.a0;
    endcase
  endfunction
  task automatic push(input int k, input logic [31:0] v, input string n);
    q.push_back('{k, v, n});
  endtask
  task automatic fire();
    -> check_now;
    #2;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.we = 1'b0;
    bus.wb_pend_clr = 1'b0;
    bus.iss_valid = 1'b0;
    bus.trigger = 1'b0;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(check_now);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (actual(e.kind) !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h expected %h", e.name, actual(e.kind), e.exp);
        end
      end
    end
  end
  initial begin
    int rs[3] = '{1, 2, 9};
    idle();
    bus.wa = '0;
    bus.wd = '0;
    bus.iss_rd = '0;
    bus.rd_addr = {5'd0, 5'd7};
    bus.rd_used = 2'b00;
    push(0, 0, "rst_rd0"); push(1, 0, "rst_rd1"); push(2, 0, "rst_stall");
    push(3, 0, "rst_cnt"); push(4, 0, "rst_ra"); push(5, 0, "rst_a0");
    fire();
    rst_n = 1'b1;
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'hDEADBEEF;
    push(0, BYP ? 32'hDEADBEEF : 32'h0, "pre_edge_x7");
    fire();
    step(); idle();
    push(0, 32'hDEADBEEF, "x7_after_edge");
    fire();
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF; bus.rd_addr = {5'd0, 5'd0};
    push(0, 0, "x0_wr_p0"); push(1, 0, "x0_wr_p1");
    fire();
    step(); idle();
    push(0, 0, "x0_p0"); push(1, 0, "x0_p1"); push(3, 0, "x0_cnt");
    fire();
    bus.trigger = 1'b1; bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h55;
    bus.rd_addr = {5'd5, 5'd0};
    step(); idle();
    push(1, 1, "trig_prio_x5");
    fire();
    bus.we = 1'b1; bus.wa = 5'd1; bus.wd = 32'h1111;
    step();
    bus.wa = 5'd10; bus.wd = 32'hA0A0;
    step(); idle();
    push(4, 32'h1111, "ra_tap"); push(5, 32'hA0A0, "a0_tap");
    fire();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    step(); idle();
    bus.rd_addr = {5'd0, 5'd3}; bus.rd_used = 2'b01;
    push(2, 1, "load_use_stall"); push(3, 1, "load_use_cnt");
    fire();
    step();
    bus.rd_used = 2'b00;
    push(2, 0, "unused_src_no_stall");
    fire();
    step();
    bus.rd_used = 2'b01;
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h10; bus.wb_pend_clr = 1'b1;
    push(2, BYP ? 32'h0 : 32'h1, "wb_cycle_stall");
    push(0, BYP ? 32'h10 : 32'h0, "wb_cycle_rd0");
    fire();
    step(); idle();
    push(2, 0, "after_wb_stall"); push(0, 32'h10, "after_wb_rd0"); push(3, 0, "after_wb_cnt");
    fire();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    step();
    bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'h44; bus.wb_pend_clr = 1'b1;
    step(); idle();
    bus.rd_addr = {5'd4, 5'd3}; bus.rd_used = 2'b10;
    push(3, 1, "set_wins_cnt"); push(2, 1, "set_wins_stall"); push(1, 32'h44, "x4_data");
    fire();
    foreach (rs[i]) begin
      bus.iss_valid = 1'b1; bus.iss_rd = AW'(rs[i]);
      step();
    end
    idle();
    push(3, 4, "multi_pend_cnt"); push(4, 32'h1111, "ra_before_rst");
    fire();
    rst_n = 1'b0;
    push(3, 0, "async_rst_cnt"); push(2, 0, "async_rst_stall");
    push(4, 0, "async_rst_ra"); push(5, 0, "async_rst_a0"); push(1, 0, "async_rst_rd1");
    fire();
    #10;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
